serial_tx_frame: RTL and testbench

Serial frame transmitter at the far end of the controller's transmit handshake. It captures a data word on PARALLEL_LOAD and, when Tx_DATA rises, shifts the word out on a single line as a start/data/stop frame. It reports completion on Tx_DONE with the level semantics the read-flow FSM expects:
- high when idle;
- low from the start request until the frame ends.

---
 rtl/serial_tx_frame.sv | 117 +++++++++++
 tb/tb_serial_tx_frame.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_frame.sv
// Start/data/stop serial frame transmitter with a holding register and a
// Tx_DONE level that drops combinationally on the start request.
module serial_tx_frame #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  PARALLEL_LOAD,
    input  logic                  Tx_DATA,
    output logic                  TX_OUT,
    output logic                  Tx_DONE,
    output logic                  TX_BUSY
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic                  tx_q, tx_d;
    logic                  start;
    logic                  bit_end;

    assign start   = Tx_DATA & ~tx_q;
    assign bit_end = (clk_cnt_q == CLK_LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            clk_cnt_q <= '0;
            tx_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            clk_cnt_q <= clk_cnt_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = START;
            START: if (bit_end) state_d = DATA;
            DATA:  if (bit_end && (bit_cnt_q == BIT_LAST)) state_d = STOP;
            STOP:  if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state; loads and starts are only honoured in IDLE.
    always_comb begin
        hold_d    = hold_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        clk_cnt_d = clk_cnt_q;
        tx_d      = Tx_DATA;
        case (state_q)
            IDLE: begin
                if (PARALLEL_LOAD) hold_d = DATA_IN;
                if (start) begin
                    shift_d   = PARALLEL_LOAD ? DATA_IN : hold_q;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            STOP: begin
                clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
            end
            default: begin
                clk_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        TX_OUT  = 1'b1;
        case (state_q)
            START:   TX_OUT = 1'b0;
            DATA:    TX_OUT = shift_q[0];
            default: TX_OUT = 1'b1;
        endcase
        TX_BUSY = (state_q != IDLE);
        Tx_DONE = (state_q == IDLE) & ~start;
    end

endmodule

// File: tb/tb_serial_tx_frame.sv
// Scoreboard bench for serial_tx_frame: an 8-bit/4-clock instance and a
// 4-bit/1-clock instance share clock and reset.
module tb_serial_tx_frame;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       pl_a = 1'b0, tx_a = 1'b0;
    logic [7:0] din_a = '0;
    logic       pl_b = 1'b0, tx_b = 1'b0;
    logic [3:0] din_b = '0;
    logic       out_a, done_a, busy_a;
    logic       out_b, done_b, busy_b;

    int         vectors = 0;
    int         miscompares = 0;
    logic       exp_q[$];

    always #5 CLK = ~CLK;

    serial_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut_a (
        .CLK(CLK), .RESET(RESET), .DATA_IN(din_a), .PARALLEL_LOAD(pl_a),
        .Tx_DATA(tx_a), .TX_OUT(out_a), .Tx_DONE(done_a), .TX_BUSY(busy_a)
    );

    serial_tx_frame #(.DATA_WIDTH(4), .CLKS_PER_BIT(1)) u_dut_b (
        .CLK(CLK), .RESET(RESET), .DATA_IN(din_b), .PARALLEL_LOAD(pl_b),
        .Tx_DATA(tx_b), .TX_OUT(out_b), .Tx_DONE(done_b), .TX_BUSY(busy_b)
    );

    task automatic drive(input bit sel, input logic pl, input logic tx, input logic [7:0] d);
        if (sel) begin
            pl_b = pl; tx_b = tx; din_b = d[3:0];
        end else begin
            pl_a = pl; tx_a = tx; din_a = d;
        end
    endtask

    function automatic logic line_of(input bit sel);
        return sel ? out_b : out_a;
    endfunction
    function automatic logic done_of(input bit sel);
        return sel ? done_b : done_a;
    endfunction
    function automatic logic busy_of(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    // Caller has driven the start at a negedge; the next posedge is e0.
    // Cycle k below is the cycle following edge e0+k.
    task automatic run_frame(input bit sel, input logic [7:0] val, input bit hold_tx,
                             input int poke_k, input int rst_k);
        int   w = sel ? 4 : 8;
        int   c = sel ? 1 : 4;
        int   f = (w + 2) * c;
        logic bv;
        logic e;
        for (int b = 0; b < w + 2; b++) begin
            bv = (b == 0) ? 1'b0 : (b <= w) ? val[b-1] : 1'b1;
            for (int r = 0; r < c; r++) exp_q.push_back(bv);
        end
        for (int k = 0; k < f; k++) begin
            @(negedge CLK);
            if (k == 0) drive(sel, 1'b0, hold_tx, 8'h00);
            if (k == poke_k) drive(sel, 1'b1, 1'b1, 8'hFF);
            if (k == poke_k + 1) drive(sel, 1'b0, 1'b0, 8'h00);
            if (k == rst_k) begin
                RESET = 1'b0;
                #1;
                vectors++;
                if (line_of(sel) !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rst_line k=%0d got=%b exp=1", k, line_of(sel));
                end
                vectors++;
                if (busy_of(sel) !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rst_busy k=%0d got=%b exp=0", k, busy_of(sel));
                end
                exp_q.delete();
                return;
            end
            #1;
            e = exp_q.pop_front();
            vectors++;
            if (line_of(sel) !== e) begin
                miscompares++;
                $display("FAIL line sel=%0d k=%0d got=%b exp=%b", sel, k, line_of(sel), e);
            end
            vectors++;
            if (busy_of(sel) !== 1'b1 || done_of(sel) !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_done sel=%0d k=%0d got=%b%b exp=10", sel, k,
                         busy_of(sel), done_of(sel));
            end
        end
        @(negedge CLK);
        #1;
        vectors++;
        if (done_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0 || line_of(sel) !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_end sel=%0d k=%0d done/busy/line got=%b%b%b exp=101", sel, f,
                     done_of(sel), busy_of(sel), line_of(sel));
        end
    endtask

    task automatic idle_cycles(input bit sel, input int n, input logic exp_done);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            #1;
            vectors++;
            if (busy_of(sel) !== 1'b0 || line_of(sel) !== 1'b1 || done_of(sel) !== exp_done) begin
                miscompares++;
                $display("FAIL idle sel=%0d i=%0d busy/line/done got=%b%b%b exp=01%b", sel, i,
                         busy_of(sel), line_of(sel), done_of(sel), exp_done);
            end
        end
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            vectors++;
            if (out_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_a line/busy/done got=%b%b%b exp=101", out_a, busy_a, done_a);
            end
            vectors++;
            if (out_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_b line/busy/done got=%b%b%b exp=101", out_b, busy_b, done_b);
            end
        end
        @(negedge CLK);
        RESET = 1'b1;
        idle_cycles(1'b0, 2, 1'b1);
        idle_cycles(1'b1, 1, 1'b1);
    endtask

    task automatic test_mode1;
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b1, 8'hA5);
        #1;
        vectors++;
        if (done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL mode1_done_at_start got=%b exp=0", done_a);
        end
        run_frame(1'b0, 8'hA5, 1'b0, -10, -1);
        idle_cycles(1'b0, 2, 1'b1);
    endtask

    task automatic test_mode0;
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b0, 8'h3C);
        #1;
        vectors++;
        if (done_a !== 1'b1) begin
            miscompares++;
            $display("FAIL mode0_done_on_load got=%b exp=1", done_a);
        end
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        #1;
        vectors++;
        if (done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL mode0_done_at_start got=%b exp=0", done_a);
        end
        run_frame(1'b0, 8'h3C, 1'b1, -10, -1);
        idle_cycles(1'b0, 6, 1'b1);
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_ignored_busy;
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        run_frame(1'b0, 8'h3C, 1'b0, 10, -1);
        idle_cycles(1'b0, 4, 1'b1);
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        run_frame(1'b0, 8'h3C, 1'b0, -10, -1);
    endtask

    task automatic test_reset_mid_frame;
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b1, 8'h5A);
        run_frame(1'b0, 8'h5A, 1'b0, -10, 17);
        @(negedge CLK);
        RESET = 1'b1;
        idle_cycles(1'b0, 2, 1'b1);
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        run_frame(1'b0, 8'h00, 1'b0, -10, -1);
    endtask

    task automatic test_narrow;
        @(negedge CLK);
        drive(1'b1, 1'b1, 1'b1, 8'h09);
        #1;
        vectors++;
        if (done_b !== 1'b0) begin
            miscompares++;
            $display("FAIL narrow_done_at_start got=%b exp=0", done_b);
        end
        run_frame(1'b1, 8'h09, 1'b0, -10, -1);
        idle_cycles(1'b1, 2, 1'b1);
    endtask

    initial begin
        test_reset();
        test_mode1();
        test_mode0();
        test_ignored_busy();
        test_reset_mid_frame();
        test_narrow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
